emu_ram_scan_ctrl: RTL and testbench
====================================

Name: emu_ram_scan_ctrl

Overview:
- Checkpoint sequencer that sits directly upstream of the DUT wrapper's RAM scan-chain ports.
- Halts the DUT and drives the RAM scan/dir/sdi controls.
- Dump: streams scanned words out to the checkpoint buffer over a valid/ready stream.
- Restore: takes words from a valid/ready stream and shifts them back into the chain.
- Replaces hand-timed testbench sequencing with a single command-driven block.

Parameters:
- DATA_WIDTH, 64, scan word width; matches ram_sdi/ram_sdo.
- CNT_WIDTH, 16, width of the word-count field.
- PRIME_CYCLES, 2, scan-enabled cycles in dump mode before ram_sdo holds the first valid word.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_dir  in  1  0 = dump, 1 = restore
- cmd_words  in  CNT_WIDTH  number of chain words (chain length)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a command completes
- halt  out  1  to DUT halt
- ram_scan  out  1  to DUT RAM scan enable
- ram_dir  out  1  to DUT RAM scan direction
- ram_sdi  out  DATA_WIDTH  to DUT RAM scan input
- ram_sdo  in  DATA_WIDTH  from DUT RAM scan output
- out_valid / out_ready / out_data[DATA_WIDTH] / out_last: dump stream
- in_valid / in_ready / in_data[DATA_WIDTH]: restore stream

Behaviour:
- Reset values: cmd_ready=1 (IDLE), busy=0, done=0, halt=0, ram_scan=0, ram_dir=0, ram_sdi=0, out_valid=0, out_last=0, in_ready=0. Internal skid buffer empty, counters 0.
- Reset mid-operation: all outputs return to reset values immediately; halt drops. Chain contents are undefined afterwards, and the checkpoint must be redone.
- Chain contract: ram_scan=0 while halted holds the chain position. In dump, once primed, ram_sdo combinationally presents the head word, and each ram_scan=1 cycle advances one word.
- Command accept: on cmd_valid && cmd_ready, latch dir and words into registers; go to HALT.
- HALT (1 cycle): halt=1, ram_scan=0, ram_dir=latched dir. Next state: PRIME if dump and words≠0; SHIFT if restore and words≠0; RELEASE if words==0.
- PRIME: ram_scan=1 for exactly PRIME_CYCLES cycles; nothing is captured. Then SHIFT.
- SHIFT, dump:
  - ram_scan = (remaining≠0) && skid has a free entry, using a registered not-full flag.
  - Each scan cycle pushes ram_sdo into a 2-entry skid buffer and decrements remaining.
  - out_valid is high while the skid is non-empty.
  - out_last marks the word with index words-1.
  - Leave SHIFT when remaining==0 and the skid is empty → RELEASE.
  - out_ready low never loses or duplicates a word; it only pauses the chain.
- SHIFT, restore:
  - ram_sdi = in_data; in_ready = 1 while remaining≠0; ram_scan = in_valid && in_ready.
  - Each handshake decrements remaining.
  - When remaining reaches 0 → TAIL.
  - in_valid low holds the chain (ram_scan=0).
- TAIL (restore only, 1 cycle): ram_scan=1, ram_dir=1, ram_sdi=0. This commits the last word. Then RELEASE.
- RELEASE (1 cycle): ram_scan=0, halt=1. Next state is IDLE, with done pulsed in the same cycle as the transition, and halt=0 from the following cycle.
- ram_dir changes only in HALT and never while ram_scan=1.
- halt is continuously 1 from HALT through RELEASE.
- cmd_valid while busy is ignored (cmd_ready=0).
- Counter: remaining is CNT_WIDTH wide and never wraps. Decrement happens only when non-zero.
- Max words = 2^CNT_WIDTH-1.

Decomposition:
- Package emu_scan_pkg holds:
  - state enum (IDLE, HALT, PRIME, SHIFT, TAIL, RELEASE)
  - DIR_DUMP=0, DIR_RESTORE=1
  - PRIME_CYCLES default
- One sub-module: emu_scan_skid, a 2-entry valid/ready skid buffer of DATA_WIDTH+1 bits (data + last), exposing a registered not_full.

Test Plan:
- Dump, words=3, out_ready=1 → halt rises 1 cycle after accept. ram_scan is high for 2 prime cycles, then 3 shift cycles. out_data equals chain words 0..2 in order, out_last only on word 2. done pulses once, and halt falls on the next cycle.
- Dump, words=8, out_ready toggled 1,0,0,1 pattern → exactly 8 words, no duplicates or drops. ram_scan never high while the skid is full.
- Restore, words=3, in_data=A,B,C with in_valid gaps of 2 cycles → ram_sdi=A,B,C on the ram_scan cycles, then 1 TAIL scan cycle with ram_dir=1. A following dump returns A,B,C.
- words=0, either direction → halt high for 2 cycles, ram_scan never asserted, done pulses.
- resetn low during dump SHIFT at word 2 of 8 → halt, ram_scan, out_valid and busy go 0 immediately. After release, cmd_ready=1 and a new dump of 8 completes normally.
- cmd_valid held high during a busy restore → second command accepted only after done, exactly one cycle after returning to IDLE.

Source files
------------

// File: rtl/emu_scan_pkg.sv
// Shared types and defaults for the RAM scan-chain checkpoint sequencer.
package emu_scan_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 64;
  localparam int unsigned CNT_WIDTH_DEF    = 16;
  localparam int unsigned PRIME_CYCLES_DEF = 2;

  localparam logic DIR_DUMP    = 1'b0;
  localparam logic DIR_RESTORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    PRIME,
    SHIFT,
    TAIL,
    RELEASE
  } state_e;

endpackage

// File: rtl/emu_scan_skid.sv
// Two-entry valid/ready skid buffer; not_full is registered so the producer
// can gate the scan chain without a combinational path through the consumer.
module emu_scan_skid #(
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push_valid,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_not_full,
  output logic             o_pop_valid,
  output logic [WIDTH-1:0] o_pop_data,
  input  logic             i_pop_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_not_full;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  assign w_push = i_push_valid && r_not_full;
  assign w_pop  = i_pop_ready && (r_count != 2'd0);

  always_comb begin
    w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_not_full <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_count_nxt;
      r_not_full <= (w_count_nxt != 2'd2);
    end
  end

  assign o_not_full  = r_not_full;
  assign o_pop_valid = (r_count != 2'd0);
  assign o_pop_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/emu_ram_scan_ctrl.sv
// Checkpoint sequencer: halts the DUT, dumps the RAM scan chain to a stream
// or restores it from a stream, then releases the DUT.
module emu_ram_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int unsigned PRIME_CYCLES = PRIME_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [CNT_WIDTH-1:0]  cmd_words,
  output logic                  busy,
  output logic                  done,
  output logic                  halt,
  output logic                  ram_scan,
  output logic                  ram_dir,
  output logic [DATA_WIDTH-1:0] ram_sdi,
  input  logic [DATA_WIDTH-1:0] ram_sdo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data
);

  localparam int unsigned PW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;

  state_e               r_state;
  state_e               w_next;
  logic                 r_dir;
  logic [CNT_WIDTH-1:0] r_rem;
  logic [PW-1:0]        r_prime;
  logic                 r_halt;
  logic                 r_busy;
  logic                 r_cmd_ready;
  logic                 r_done;
  logic                 r_ram_dir;

  logic                  w_scan;
  logic                  w_push;
  logic                  w_in_ready;
  logic [DATA_WIDTH-1:0] w_sdi;
  logic                  w_not_full;
  logic                  w_skid_valid;
  logic [DATA_WIDTH:0]   w_skid_data;

  // Next state and combinational chain controls
  always_comb begin
    w_next     = r_state;
    w_scan     = 1'b0;
    w_push     = 1'b0;
    w_in_ready = 1'b0;
    w_sdi      = '0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) w_next = HALT;
      end
      HALT: begin
        if (r_rem == '0)                w_next = RELEASE;
        else if (r_dir == DIR_RESTORE)  w_next = SHIFT;
        else                            w_next = PRIME;
      end
      PRIME: begin
        w_scan = 1'b1;
        if (r_prime == PW'(PRIME_CYCLES - 1)) w_next = SHIFT;
      end
      SHIFT: begin
        if (r_dir == DIR_DUMP) begin
          w_scan = (r_rem != '0) && w_not_full;
          w_push = w_scan;
          if ((r_rem == '0) && !w_skid_valid) w_next = RELEASE;
        end else begin
          w_in_ready = (r_rem != '0);
          w_scan     = in_valid && w_in_ready;
          w_sdi      = in_data;
          if (w_scan && (r_rem == CNT_WIDTH'(1))) w_next = TAIL;
        end
      end
      TAIL: begin
        w_scan = 1'b1;
        w_next = RELEASE;
      end
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_dir       <= DIR_DUMP;
      r_rem       <= '0;
      r_prime     <= '0;
      r_halt      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_ram_dir   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_halt      <= (w_next != IDLE);
      r_busy      <= (w_next != IDLE);
      r_cmd_ready <= (w_next == IDLE);
      r_done      <= (w_next == RELEASE);
      // Direction only ever changes on entry to HALT, when ram_scan is low
      if ((r_state == IDLE) && cmd_valid) begin
        r_dir     <= cmd_dir;
        r_rem     <= cmd_words;
        r_ram_dir <= cmd_dir;
      end else if ((r_state == SHIFT) && w_scan && (r_rem != '0)) begin
        r_rem <= r_rem - CNT_WIDTH'(1);
      end
      if (r_state == PRIME) r_prime <= r_prime + PW'(1);
      else                  r_prime <= '0;
    end
  end

  emu_scan_skid #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk          (clk),
    .resetn       (resetn),
    .i_push_valid (w_push),
    .i_push_data  ({(r_rem == CNT_WIDTH'(1)), ram_sdo}),
    .o_not_full   (w_not_full),
    .o_pop_valid  (w_skid_valid),
    .o_pop_data   (w_skid_data),
    .i_pop_ready  (out_ready)
  );

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign halt      = r_halt;
  assign ram_scan  = w_scan;
  assign ram_dir   = r_ram_dir;
  assign ram_sdi   = w_sdi;
  assign in_ready  = w_in_ready;
  assign out_valid = w_skid_valid;
  assign out_data  = w_skid_data[DATA_WIDTH-1:0];
  assign out_last  = w_skid_data[DATA_WIDTH];

endmodule

// File: tb/tb_emu_ram_scan_ctrl.sv
// Bench for emu_ram_scan_ctrl with a behavioural RAM scan chain and a
// queue-based scoreboard for the dump stream and the restore ram_sdi words.
module tb_emu_ram_scan_ctrl;

  localparam int unsigned DW    = 64;
  localparam int unsigned CW    = 16;
  localparam int unsigned PRIME = 2;
  localparam logic [3:0]  OR_PAT = 4'b1001;

  localparam logic [63:0] CHAIN_INIT [8] = '{
    64'hA000_0000_0000_0000, 64'hA111_1111_1111_1111,
    64'hA222_2222_2222_2222, 64'hA333_3333_3333_3333,
    64'hA444_4444_4444_4444, 64'hA555_5555_5555_5555,
    64'hA666_6666_6666_6666, 64'hA777_7777_7777_7777};

  localparam logic [63:0] WA = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] WB = 64'hDEAD_BEEF_0000_0002;
  localparam logic [63:0] WC = 64'hDEAD_BEEF_0000_0003;
  localparam logic [63:0] WD = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WE = 64'hFEDC_BA98_7654_3210;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [CW-1:0] cmd_words;
  logic          busy;
  logic          done;
  logic          halt;
  logic          ram_scan;
  logic          ram_dir;
  logic [DW-1:0] ram_sdi;
  logic [DW-1:0] ram_sdo;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  always #5 clk = ~clk;

  emu_ram_scan_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_words (cmd_words),
    .busy      (busy),
    .done      (done),
    .halt      (halt),
    .ram_scan  (ram_scan),
    .ram_dir   (ram_dir),
    .ram_sdi   (ram_sdi),
    .ram_sdo   (ram_sdo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data)
  );

  // Behavioural scan chain: primes, then shifts out; restore commits one scan late
  logic [63:0] chain [8] = CHAIN_INIT;
  logic [3:0]  rd_idx = '0;
  logic [3:0]  wr_idx = '0;
  logic [3:0]  prime_seen = '0;
  logic [63:0] pend = '0;
  logic        pend_v = 1'b0;
  logic        halt_q = 1'b0;

  assign ram_sdo = chain[rd_idx[2:0]];

  always @(posedge clk) begin
    halt_q <= halt;
    if (halt && !halt_q) begin
      rd_idx     <= '0;
      wr_idx     <= '0;
      prime_seen <= '0;
      pend_v     <= 1'b0;
    end else if (ram_scan) begin
      if (!ram_dir) begin
        if (prime_seen < 4'(PRIME)) prime_seen <= prime_seen + 4'd1;
        else                        rd_idx     <= rd_idx + 4'd1;
      end else begin
        if (pend_v) begin
          chain[wr_idx[2:0]] <= pend;
          wr_idx             <= wr_idx + 4'd1;
        end
        pend   <= ram_sdi;
        pend_v <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        last;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] sdi_q [$];
  logic [63:0] golden [8];

  int n_checks;
  int n_fail;
  int scan_cnt;
  int halt_cnt;
  int done_cnt;
  int pop_cnt;
  int acc_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t        e;
    logic [63:0] s;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (ram_scan) scan_cnt++;
        if (halt) halt_cnt++;
        if (done) done_cnt++;
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (out_valid && out_ready) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_extra: got word %0h, expected no word", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_last", out_last, e.last);
          end
        end
        if (ram_scan && ram_dir) begin
          if (sdi_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sdi_extra: got scan with sdi %0h, expected none", ram_sdi);
          end else begin
            s = sdi_q.pop_front();
            chk("ram_sdi", ram_sdi, s);
          end
        end
      end
    end
  endtask

  task automatic push_dump_exp(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = golden[i];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic dir, input int unsigned words, input bit keep);
    int t;
    @(posedge clk); #1;
    cmd_dir   = dir;
    cmd_words = CW'(words);
    cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    chk("halt_before_accept", halt, 1'b0);
    @(posedge clk); #1;
    chk("halt_rise", halt, 1'b1);
    if (keep) begin
      cmd_dir   = 1'b0;
      cmd_words = '0;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input bit toggle);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 500) begin
      @(posedge clk); #1;
      if (toggle) out_ready = OR_PAT[c % 4];
      @(negedge clk);
      if (done) seen = 1'b1;
      c++;
    end
    chk("done_seen", seen, 1'b1);
    out_ready = 1'b1;
  endtask

  task automatic feed(input logic [63:0] d);
    int t;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("in_handshake", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    chk("halt_fall", halt, 1'b0);
    chk("idle_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s_scan, s_halt, s_done, s_pop, s_acc, t;
    n_checks = 0; n_fail = 0;
    scan_cnt = 0; halt_cnt = 0; done_cnt = 0; pop_cnt = 0; acc_cnt = 0;
    for (int i = 0; i < 8; i++) golden[i] = CHAIN_INIT[i];
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_words = '0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_ram_scan", ram_scan, 1'b0);
    chk("rst_ram_dir", ram_dir, 1'b0);
    chk("rst_ram_sdi", ram_sdi, 64'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Dump of 3 with a free-flowing sink
    push_dump_exp(3);
    s_scan = scan_cnt; s_done = done_cnt;
    issue(1'b0, 3, 1'b0);
    wait_done(1'b0);
    chk("dump3_scans", scan_cnt - s_scan, 5);
    chk("dump3_done_once", done_cnt - s_done, 1);
    chk("dump3_drained", exp_q.size(), 0);
    after_done();

    // Dump of 8 with a stalling sink
    push_dump_exp(8);
    s_scan = scan_cnt;
    issue(1'b0, 8, 1'b0);
    wait_done(1'b1);
    chk("dump8_scans", scan_cnt - s_scan, 10);
    chk("dump8_drained", exp_q.size(), 0);
    after_done();

    // Restore A,B,C with gapped input, then dump it back
    sdi_q.push_back(WA); sdi_q.push_back(WB); sdi_q.push_back(WC); sdi_q.push_back(64'h0);
    s_scan = scan_cnt; s_done = done_cnt;
    issue(1'b1, 3, 1'b0);
    feed(WA); feed(WB); feed(WC);
    wait_done(1'b0);
    chk("restore3_scans", scan_cnt - s_scan, 4);
    chk("restore3_sdi_drained", sdi_q.size(), 0);
    chk("restore3_done_once", done_cnt - s_done, 1);
    chk("restore3_dir_held", ram_dir, 1'b1);
    after_done();
    golden[0] = WA; golden[1] = WB; golden[2] = WC;
    push_dump_exp(3);
    issue(1'b0, 3, 1'b0);
    wait_done(1'b0);
    chk("readback_drained", exp_q.size(), 0);
    after_done();

    // Zero-word commands in both directions
    for (int d = 0; d < 2; d++) begin
      s_scan = scan_cnt; s_halt = halt_cnt; s_done = done_cnt;
      issue(d[0], 0, 1'b0);
      wait_done(1'b0);
      chk("zero_halt_cycles", halt_cnt - s_halt, 2);
      chk("zero_no_scan", scan_cnt - s_scan, 0);
      chk("zero_done_once", done_cnt - s_done, 1);
      after_done();
    end

    // Reset in the middle of an 8-word dump
    push_dump_exp(8);
    s_pop = pop_cnt;
    issue(1'b0, 8, 1'b0);
    t = 0;
    while ((pop_cnt - s_pop) < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_reached", (pop_cnt - s_pop) >= 2, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid_halt", halt, 1'b0);
    chk("rst_mid_ram_scan", ram_scan, 1'b0);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    push_dump_exp(8);
    s_scan = scan_cnt;
    issue(1'b0, 8, 1'b0);
    wait_done(1'b0);
    chk("post_rst_scans", scan_cnt - s_scan, 10);
    chk("post_rst_drained", exp_q.size(), 0);
    after_done();

    // cmd_valid held through a busy restore of D,E
    sdi_q.push_back(WD); sdi_q.push_back(WE); sdi_q.push_back(64'h0);
    s_done = done_cnt;
    issue(1'b1, 2, 1'b1);
    s_acc = acc_cnt;
    feed(WD); feed(WE);
    wait_done(1'b0);
    chk("busy_no_accept", acc_cnt - s_acc, 0);
    @(posedge clk); #1;
    chk("held_idle_ready", cmd_ready, 1'b1);
    chk("held_idle_halt", halt, 1'b0);
    @(posedge clk); #1;
    chk("held_accept_once", acc_cnt - s_acc, 1);
    chk("held_second_halt", halt, 1'b1);
    chk("held_second_busy", busy, 1'b1);
    cmd_valid = 1'b0;
    wait_done(1'b0);
    chk("held_done_count", done_cnt - s_done, 2);
    chk("held_sdi_drained", sdi_q.size(), 0);
    after_done();
    golden[0] = WD; golden[1] = WE;
    push_dump_exp(3);
    issue(1'b0, 3, 1'b0);
    wait_done(1'b0);
    chk("final_drained", exp_q.size(), 0);
    after_done();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
